button_bank: RTL and testbench

// - N-channel successor of the single-button edge/lockout block: per channel, sync
//   raw bt, emit one-cycle press pulse on rising edge, ignore re-presses inside a

---
 rtl/button_bank_if.sv | 12 +
 rtl/button_bank.sv | 132 +++++++++++++
 tb/tb_button_bank.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_bank_if.sv
// Button bank signal bundle: raw button levels in, accepted-press, long-press and held levels out.
interface button_bank_if #(
   parameter int N_BTN = 5
);
   logic [N_BTN-1:0] bt;
   logic [N_BTN-1:0] pos;
   logic [N_BTN-1:0] long_pos;
   logic [N_BTN-1:0] held;

   modport master (output bt, input pos, long_pos, held);
   modport slave  (input bt, output pos, long_pos, held);
endinterface

// File: rtl/button_bank.sv
// N-channel push-button front end: sync, press pulse with lockout, long-press pulse, held level.
// Optional auto-repeat while a long press is held: define BUTTON_BANK_AUTOREPEAT_EN.
module button_bank_chan #(
   parameter int LOCK_CYCLES   = 8,
   parameter int LONG_CYCLES   = 20,
   parameter int REPEAT_CYCLES = 5,
   parameter int CW            = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic bt,
   output logic pos,
   output logic long_pos,
   output logic held
);
   typedef enum logic [1:0] {IDLE, PRESS, HOLD, LOCK} state_t;

   localparam logic [CW-1:0] LOCK_END = CW'(LOCK_CYCLES - 1);
   localparam logic [CW-1:0] LONG_END = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(LONG_CYCLES);
`ifdef BUTTON_BANK_AUTOREPEAT_EN
   localparam logic [CW-1:0] REP_END  = CW'(REPEAT_CYCLES - 1);
`endif

   if (LONG_CYCLES <= LOCK_CYCLES || LOCK_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
      $error("button_bank: need LONG_CYCLES > LOCK_CYCLES >= 1 and REPEAT_CYCLES >= 1");
   end

   logic          s1, s2, s3;
   logic          lvl, rise;
   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic          pos_c, long_c, rep_hit;
   logic          pend_pos, pend_long;

   assign lvl  = s2;
   assign rise = s2 & ~s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bt;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:  if (rise) nxt = PRESS;
         // a release always wins over a long threshold reached in the same cycle
         PRESS: if (!lvl)                nxt = (cnt < LOCK_END) ? LOCK : IDLE;
                else if (cnt == LONG_END) nxt = HOLD;
         HOLD:  if (!lvl) nxt = IDLE;
         LOCK:  if (cnt == LOCK_END) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      rep_hit = 1'b0;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
      rep_hit = (state == HOLD) && lvl && (cnt == REP_END);
`endif
      pos_c  = ((state == IDLE) && rise) || rep_hit;
      long_c = (state == PRESS) && lvl && (cnt == LONG_END);
   end

   // cnt sits at 0 while idle, so acceptance always starts the count from zero
   always_ff @(posedge clk) begin
      if (rst || state == IDLE) cnt <= '0;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
      else if (long_c || rep_hit) cnt <= '0;
`endif
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
   end

   // pulses pass through one staging register so pos lands three cycles after the first sample
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_pos  <= 1'b0;
         pend_long <= 1'b0;
         pos       <= 1'b0;
         long_pos  <= 1'b0;
         held      <= 1'b0;
      end else begin
         pend_pos  <= pos_c;
         pend_long <= long_c;
         pos       <= pend_pos;
         long_pos  <= pend_long;
         held      <= s2;
      end
   end
endmodule

module button_bank #(
   parameter int N_BTN         = 5,
   parameter int LOCK_CYCLES   = 25_000_000,
   parameter int LONG_CYCLES   = 100_000_000,
   parameter int REPEAT_CYCLES = 20_000_000
) (
   input logic          clk,
   input logic          rst,
   button_bank_if.slave bus
);
   localparam int CW = $clog2(LONG_CYCLES + 1);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      button_bank_chan #(
         .LOCK_CYCLES  (LOCK_CYCLES),
         .LONG_CYCLES  (LONG_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES),
         .CW           (CW)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .bt      (bus.bt[i]),
         .pos     (bus.pos[i]),
         .long_pos(bus.long_pos[i]),
         .held    (bus.held[i])
      );
   end
endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: timeline reference model plus directed scenario counts.
module tb_button_bank;
   localparam int N = 2, LK = 8, LG = 20, RP = 5, HIST = 64;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
   localparam int EXP_REP = 1;
`else
   localparam int EXP_REP = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   button_bank_if #(.N_BTN(N)) bus ();
   button_bank #(.N_BTN(N), .LOCK_CYCLES(LK), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   // Reference model: sampled-level history plus per-channel press timestamps.
   bit smp [N][HIST];
   int cyc = 0;
   int acc [N];      // edge of the accepted press still held, -1 if none
   int hold_st [N];  // edge the long press was recognised, -1 if none
   int free_at [N];  // first edge at which a new press may be accepted
   logic [N-1:0] exp_pos = '0, exp_long = '0, exp_held = '0, nxt_pos = '0, nxt_long = '0;

   function automatic bit sample(int ch, int t);
      return (t < 0) ? 1'b0 : smp[ch][t % HIST];
   endfunction

   always @(posedge clk) begin
      bit lv, rs;
      int age;
      exp_pos  = nxt_pos;
      exp_long = nxt_long;
      nxt_pos  = '0;
      nxt_long = '0;
      for (int ch = 0; ch < N; ch++) begin
         smp[ch][cyc % HIST] = bus.bt[ch];
         if (rst) begin
            for (int d = 0; d < 3; d++) if (cyc - d >= 0) smp[ch][(cyc - d) % HIST] = 1'b0;
            acc[ch] = -1; hold_st[ch] = -1; free_at[ch] = 0;
            exp_pos[ch] = 1'b0; exp_long[ch] = 1'b0;
         end else begin
            lv = sample(ch, cyc - 2);
            rs = lv && !sample(ch, cyc - 3);
            if (hold_st[ch] >= 0) begin
               if (!lv) begin hold_st[ch] = -1; free_at[ch] = cyc + 1; end
               else if (EXP_REP == 1 && (cyc - hold_st[ch]) % RP == 0) nxt_pos[ch] = 1'b1;
            end else if (acc[ch] >= 0) begin
               age = cyc - 1 - acc[ch];
               if (!lv) begin
                  free_at[ch] = (age < LK - 1) ? acc[ch] + LK + 1 : cyc + 1;
                  acc[ch] = -1;
               end else if (age == LG - 1) begin
                  nxt_long[ch] = 1'b1; hold_st[ch] = cyc; acc[ch] = -1;
               end
            end else if (cyc >= free_at[ch] && rs) begin
               acc[ch] = cyc; nxt_pos[ch] = 1'b1;
            end
         end
         exp_held[ch] = sample(ch, cyc - 2);
      end
      cyc++;
   end

   task automatic test_reset();
      for (int i = 0; i < 34; i++) begin
         rst = (i < 4);
         bus.bt = (i < 4) ? 2'($urandom) : 2'b00;
         @(negedge clk);
         checks++;
         if ({bus.pos, bus.long_pos, bus.held} !== {exp_pos, exp_long, exp_held}) begin
            errors++;
            $display("FAIL reset i=%0d pos=%b/%b long=%b/%b held=%b/%b (dut/model)", i, bus.pos, exp_pos, bus.long_pos, exp_long, bus.held, exp_held);
         end
         if (i < 4) begin
            checks++;
            if ({bus.pos, bus.long_pos, bus.held} !== 6'b0) begin
               errors++;
               $display("FAIL reset_zero i=%0d outputs=%b required 0", i, {bus.pos, bus.long_pos, bus.held});
            end
         end
      end
   endtask

   task automatic test_single();
      int n0 = 0, n1 = 0, first = -1;
      for (int i = 0; i < 30; i++) begin
         bus.bt = (i < 4) ? 2'b01 : 2'b00;
         @(negedge clk);
         checks++;
         if ({bus.pos, bus.long_pos, bus.held} !== {exp_pos, exp_long, exp_held}) begin
            errors++;
            $display("FAIL single i=%0d pos=%b/%b long=%b/%b held=%b/%b (dut/model)", i, bus.pos, exp_pos, bus.long_pos, exp_long, bus.held, exp_held);
         end
         if (bus.pos[0] === 1'b1) begin n0++; if (first < 0) first = i; end
         if (bus.pos[1] === 1'b1) n1++;
      end
      checks++;
      if (n0 != 1 || n1 != 0 || first != 3) begin
         errors++;
         $display("FAIL single_count pos0=%0d pos1=%0d first=%0d required 1 0 3", n0, n1, first);
      end
   endtask

   task automatic test_lockout();
      int n0 = 0;
      for (int i = 0; i < 50; i++) begin
         bus.bt = (i < 2 || (i >= 5 && i < 7) || (i >= 20 && i < 22)) ? 2'b01 : 2'b00;
         @(negedge clk);
         checks++;
         if ({bus.pos, bus.long_pos, bus.held} !== {exp_pos, exp_long, exp_held}) begin
            errors++;
            $display("FAIL lockout i=%0d pos=%b/%b long=%b/%b held=%b/%b (dut/model)", i, bus.pos, exp_pos, bus.long_pos, exp_long, bus.held, exp_held);
         end
         if (bus.pos[0] === 1'b1) n0++;
      end
      checks++;
      if (n0 != 2) begin
         errors++;
         $display("FAIL lockout_count pos0=%0d required 2", n0);
      end
   endtask

   task automatic test_long();
      int np = 0, nl = 0, first = -1, lat = -1;
      for (int i = 0; i < 60; i++) begin
         bus.bt = (i < 30) ? 2'b10 : 2'b00;
         @(negedge clk);
         checks++;
         if ({bus.pos, bus.long_pos, bus.held} !== {exp_pos, exp_long, exp_held}) begin
            errors++;
            $display("FAIL long i=%0d pos=%b/%b long=%b/%b held=%b/%b (dut/model)", i, bus.pos, exp_pos, bus.long_pos, exp_long, bus.held, exp_held);
         end
         if (bus.pos[1] === 1'b1) begin np++; if (first < 0) first = i; end
         if (bus.long_pos[1] === 1'b1) begin nl++; lat = i - first; end
      end
      checks++;
      if (np != 1 + EXP_REP || nl != 1 || lat != LG) begin
         errors++;
         $display("FAIL long_count pos1=%0d long1=%0d lat=%0d required %0d 1 %0d", np, nl, lat, 1 + EXP_REP, LG);
      end
   endtask

   task automatic test_simul();
      int nb = 0, n0 = 0, n1 = 0;
      for (int i = 0; i < 45; i++) begin
         bus.bt[0] = (i < 3) || (i >= 8 && i < 10);
         bus.bt[1] = (i < 12) || (i >= 15 && i < 17);
         @(negedge clk);
         checks++;
         if ({bus.pos, bus.long_pos, bus.held} !== {exp_pos, exp_long, exp_held}) begin
            errors++;
            $display("FAIL simul i=%0d pos=%b/%b long=%b/%b held=%b/%b (dut/model)", i, bus.pos, exp_pos, bus.long_pos, exp_long, bus.held, exp_held);
         end
         if (bus.pos === 2'b11) nb++;
         if (bus.pos[0] === 1'b1) n0++;
         if (bus.pos[1] === 1'b1) n1++;
      end
      checks++;
      if (nb != 1 || n0 != 1 || n1 != 2) begin
         errors++;
         $display("FAIL simul_count both=%0d pos0=%0d pos1=%0d required 1 1 2", nb, n0, n1);
      end
   endtask

   task automatic test_rst_mid();
      int n0 = 0, last = -1;
      for (int i = 0; i < 40; i++) begin
         bus.bt[0] = (i < 15);
         bus.bt[1] = (i < 2);
         rst = (i == 5);
         @(negedge clk);
         checks++;
         if ({bus.pos, bus.long_pos, bus.held} !== {exp_pos, exp_long, exp_held}) begin
            errors++;
            $display("FAIL rst_mid i=%0d pos=%b/%b long=%b/%b held=%b/%b (dut/model)", i, bus.pos, exp_pos, bus.long_pos, exp_long, bus.held, exp_held);
         end
         if (i == 5) begin
            checks++;
            if ({bus.pos, bus.long_pos, bus.held} !== 6'b0) begin
               errors++;
               $display("FAIL rst_mid_zero outputs=%b required 0", {bus.pos, bus.long_pos, bus.held});
            end
         end
         if (bus.pos[0] === 1'b1) begin n0++; last = i; end
      end
      rst = 1'b0;
      checks++;
      if (n0 != 2 || last != 9) begin
         errors++;
         $display("FAIL rst_mid_count pos0=%0d last=%0d required 2 9", n0, last);
      end
   endtask

   task automatic test_long_edge();
      int n0 = 0, l0 = 0, l1 = 0;
      for (int i = 0; i < 50; i++) begin
         bus.bt[0] = (i < 20) || (i >= 25 && i < 27);
         bus.bt[1] = (i < 21);
         @(negedge clk);
         checks++;
         if ({bus.pos, bus.long_pos, bus.held} !== {exp_pos, exp_long, exp_held}) begin
            errors++;
            $display("FAIL long_edge i=%0d pos=%b/%b long=%b/%b held=%b/%b (dut/model)", i, bus.pos, exp_pos, bus.long_pos, exp_long, bus.held, exp_held);
         end
         if (bus.pos[0] === 1'b1) n0++;
         if (bus.long_pos[0] === 1'b1) l0++;
         if (bus.long_pos[1] === 1'b1) l1++;
      end
      checks++;
      if (n0 != 2 || l0 != 0 || l1 != 1) begin
         errors++;
         $display("FAIL long_edge_count pos0=%0d long0=%0d long1=%0d required 2 0 1", n0, l0, l1);
      end
   endtask

   task automatic test_random();
      int run [N];
      for (int ch = 0; ch < N; ch++) run[ch] = 0;
      for (int i = 0; i < 1500; i++) begin
         for (int ch = 0; ch < N; ch++) begin
            if (run[ch] == 0) begin
               bus.bt[ch] = 1'($urandom);
               run[ch] = int'($urandom_range(1, 35));
            end
            run[ch]--;
         end
         rst = ($urandom_range(0, 199) == 0);
         @(negedge clk);
         checks++;
         if ({bus.pos, bus.long_pos, bus.held} !== {exp_pos, exp_long, exp_held}) begin
            errors++;
            $display("FAIL random i=%0d pos=%b/%b long=%b/%b held=%b/%b (dut/model)", i, bus.pos, exp_pos, bus.long_pos, exp_long, bus.held, exp_held);
         end
         checks++;
         if ((bus.pos & bus.long_pos) !== 2'b00) begin
            errors++;
            $display("FAIL random_excl i=%0d pos=%b long=%b required no overlap", i, bus.pos, bus.long_pos);
         end
      end
      rst = 1'b0;
      bus.bt = '0;
   endtask

   initial begin
      bus.bt = '0;
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_lockout();
      test_long();
      test_simul();
      test_rst_mid();
      test_long_edge();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
